// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
// Entry layout and drop-counter saturation helper for the RX buffer.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int DROP_CNT_W  = 8;

  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  // Increment that sticks at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side valid/ready handshakes of the UART RX buffer.
interface uart_rx_fifo_if import uart_pkg::*; #(
  parameter int DATA_WIDTH = UART_DATA_W
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_parity_err;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_perr;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, in_parity_err, out_ready,
    output in_ready, out_data, out_perr, out_valid
  );

  modport master (
    output in_data, in_valid, in_parity_err, out_ready,
    input  in_ready, out_data, out_perr, out_valid
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Register array storage for the RX FIFO: one synchronous write port,
// one asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 9,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: tagged circular FIFO with first-word-fall-through output,
// overrun flag and saturating drop counter.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DATA_WIDTH   = UART_DATA_W,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 1,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  uart_rx_fifo_if.slave         rx,
  input  logic                  flush,
  input  logic                  overrun_clr,
  output logic [ADDR_W:0]       level,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [ADDR_W:0]     PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [DROP_CNT_W-1:0] CNT_ONE = DROP_CNT_W'(1);

  logic [ADDR_W:0]       wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
  logic                  err_pending_r, err_pending_nx_s;
  logic                  overrun_r, overrun_nx_s;
  logic [DROP_CNT_W-1:0] drop_cnt_r, drop_cnt_nx_s;
  logic                  full_s, empty_s, in_ready_s;
  logic                  push_s, pop_s, store_s, drop_s;
  logic [DATA_WIDTH:0]   wdata_s, rdata_s;

  assign full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                   (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign in_ready_s = (DROP_ON_FULL != 0) ? 1'b1 : ~full_s;

  assign push_s  = rx.in_valid & in_ready_s;
  assign pop_s   = ~empty_s & rx.out_ready;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign store_s = push_s & (~full_s | pop_s) & ~flush;
  assign drop_s  = push_s & full_s & ~pop_s & ~flush;
  assign wdata_s = {err_pending_r | rx.in_parity_err, rx.in_data};

  // Next-state for pointers, pending parity error, overrun and drop count.
  always_comb begin
    wr_ptr_nx_s      = wr_ptr_r;
    rd_ptr_nx_s      = rd_ptr_r;
    err_pending_nx_s = err_pending_r;
    overrun_nx_s     = overrun_r;
    drop_cnt_nx_s    = drop_cnt_r;
    if (flush) begin
      wr_ptr_nx_s      = '0;
      rd_ptr_nx_s      = '0;
      err_pending_nx_s = 1'b0;
    end else begin
      wr_ptr_nx_s = store_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_nx_s = pop_s   ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      if (push_s) begin
        err_pending_nx_s = 1'b0;
      end else if (rx.in_parity_err) begin
        err_pending_nx_s = 1'b1;
      end else begin
        err_pending_nx_s = err_pending_r;
      end
    end
    // A drop in the clear cycle is counted as the first of a fresh tally.
    if (drop_s) begin
      overrun_nx_s  = 1'b1;
      drop_cnt_nx_s = overrun_clr ? CNT_ONE : sat_inc(drop_cnt_r);
    end else if (overrun_clr) begin
      overrun_nx_s  = 1'b0;
      drop_cnt_nx_s = '0;
    end else begin
      overrun_nx_s  = overrun_r;
      drop_cnt_nx_s = drop_cnt_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      err_pending_r <= 1'b0;
      overrun_r     <= 1'b0;
      drop_cnt_r    <= '0;
    end else begin
      wr_ptr_r      <= wr_ptr_nx_s;
      rd_ptr_r      <= rd_ptr_nx_s;
      err_pending_r <= err_pending_nx_s;
      overrun_r     <= overrun_nx_s;
      drop_cnt_r    <= drop_cnt_nx_s;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_mem (
    .clk   (clk),
    .we    (store_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (wdata_s),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (rdata_s)
  );

  assign rx.in_ready  = in_ready_s;
  assign rx.out_valid = ~empty_s;
  assign rx.out_data  = empty_s ? '0 : rdata_s[DATA_WIDTH-1:0];
  assign rx.out_perr  = empty_s ? 1'b0 : rdata_s[DATA_WIDTH];
  assign level        = wr_ptr_r - rd_ptr_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign overrun      = overrun_r;
  assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one drop-on-full instance and one
// backpressure instance, selected by sel and checked against a small model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  logic [7:0] in_data;
  logic       in_valid, in_parity_err, out_ready, flush, overrun_clr;

  uart_rx_fifo_if #(.DATA_WIDTH(8)) ifa ();
  uart_rx_fifo_if #(.DATA_WIDTH(8)) ifb ();

  assign ifa.in_data       = in_data;
  assign ifa.in_valid      = in_valid & ~sel;
  assign ifa.in_parity_err = in_parity_err & ~sel;
  assign ifa.out_ready     = out_ready & ~sel;
  assign ifb.in_data       = in_data;
  assign ifb.in_valid      = in_valid & sel;
  assign ifb.in_parity_err = in_parity_err & sel;
  assign ifb.out_ready     = out_ready & sel;

  logic       flush_a, flush_b, clr_a, clr_b;
  logic [AW:0] level_a, level_b;
  logic       full_a, full_b, empty_a, empty_b, ovr_a, ovr_b;
  logic [7:0] drop_a, drop_b;

  assign flush_a = flush & ~sel;
  assign flush_b = flush & sel;
  assign clr_a   = overrun_clr & ~sel;
  assign clr_b   = overrun_clr & sel;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(1)) dut_a (
    .clk(clk), .rst_l(rst_l), .rx(ifa.slave), .flush(flush_a), .overrun_clr(clr_a),
    .level(level_a), .full(full_a), .empty(empty_a), .overrun(ovr_a), .drop_cnt(drop_a)
  );

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(0)) dut_b (
    .clk(clk), .rst_l(rst_l), .rx(ifb.slave), .flush(flush_b), .overrun_clr(clr_b),
    .level(level_b), .full(full_b), .empty(empty_b), .overrun(ovr_b), .drop_cnt(drop_b)
  );

  logic [7:0]  o_data, o_drop;
  logic        o_valid, o_perr, o_ready, o_full, o_empty, o_ovr;
  logic [AW:0] o_level;

  assign o_data  = sel ? ifb.out_data  : ifa.out_data;
  assign o_perr  = sel ? ifb.out_perr  : ifa.out_perr;
  assign o_valid = sel ? ifb.out_valid : ifa.out_valid;
  assign o_ready = sel ? ifb.in_ready  : ifa.in_ready;
  assign o_level = sel ? level_b : level_a;
  assign o_full  = sel ? full_b  : full_a;
  assign o_empty = sel ? empty_b : empty_a;
  assign o_ovr   = sel ? ovr_b   : ovr_a;
  assign o_drop  = sel ? drop_b  : drop_a;

  int        n_checks = 0;
  int        n_fail   = 0;
  int        m_level;
  bit        m_err, m_ovr;
  int        m_drop;
  rx_entry_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_level = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"},    o_level, m_level);
    check({tag, "_full"},     o_full,  (m_level == DEPTH));
    check({tag, "_empty"},    o_empty, (m_level == 0));
    check({tag, "_valid"},    o_valid, (m_level != 0));
    check({tag, "_overrun"},  o_ovr,   m_ovr);
    check({tag, "_drop_cnt"}, o_drop,  m_drop);
    check({tag, "_in_ready"}, o_ready, (sel == 1'b0) || (m_level < DEPTH));
  endtask

  task automatic push_word(input logic [7:0] d);
    rx_entry_t e;
    bit        acc;
    acc    = (sel == 1'b0) || (m_level < DEPTH);
    e.perr = m_err | in_parity_err;
    e.data = d;
    in_data  = d;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    if (acc) begin
      m_err = 1'b0;
      if (m_level < DEPTH) begin
        exp_q.push_back(e);
        m_level++;
      end else begin
        m_ovr = 1'b1;
        if (overrun_clr) m_drop = 1;
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    rx_entry_t e;
    check({tag, "_pop_valid"}, o_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_size"}, exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_data"}, o_data, e.data);
    check({tag, "_perr"}, o_perr, e.perr);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    m_level--;
  endtask

  initial begin
    rx_entry_t e;
    sel = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_parity_err = 1'b0;
    out_ready = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    model_clear();
    m_ovr = 1'b0; m_drop = 0;
    #12 rst_l = 1'b1;
    cycle();

    // Reset state
    check("reset_out_data", o_data, 8'h00);
    check("reset_out_perr", o_perr, 1'b0);
    check_status("reset");

    // Single word with one-cycle latency
    push_word(8'h3C);
    check("t1_level", o_level, 5'd1);
    pop_check("t1");
    check_status("t1_after_pop");

    // Parity error pulse ahead of the word tags that word only
    in_parity_err = 1'b1;
    cycle();
    in_parity_err = 1'b0;
    m_err = 1'b1;
    cycle();
    cycle();
    push_word(8'hA5);
    push_word(8'h5A);
    pop_check("t2_a5");
    pop_check("t2_5a");

    // Overfill by two with the consumer stalled
    for (int i = 0; i < 18; i++) push_word(8'h10 + 8'(i));
    check_status("t3_full");
    check("t3_drop_cnt", o_drop, 8'd2);

    // Push and pop together on a full FIFO
    e = exp_q.pop_front();
    check("t4_head_data", o_data, e.data);
    in_data = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    e.perr = m_err; e.data = 8'h77;
    exp_q.push_back(e);
    m_err = 1'b0;
    check_status("t4_same_cycle");
    for (int i = 0; i < DEPTH; i++) pop_check("t4_drain");
    check_status("t4_drained");

    // Drop coinciding with overrun_clr
    for (int i = 0; i < DEPTH; i++) push_word(8'h40 + 8'(i));
    overrun_clr = 1'b1;
    push_word(8'hEE);
    overrun_clr = 1'b0;
    check_status("t6_clr_drop");
    check("t6_drop_is_one", o_drop, 8'd1);

    // Flush while full with a word arriving: nothing counted, overrun kept
    flush = 1'b1; in_data = 8'hDD; in_valid = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    check_status("t6_flush");

    // Asynchronous reset in the middle of a stream
    push_word(8'h11);
    push_word(8'h22);
    in_data = 8'h33; in_valid = 1'b1;
    rst_l = 1'b0;
    #1;
    model_clear();
    m_ovr = 1'b0; m_drop = 0;
    check("t6_rst_out_data", o_data, 8'h00);
    check("t6_rst_out_perr", o_perr, 1'b0);
    check_status("t6_rst");
    in_valid = 1'b0;
    #1 rst_l = 1'b1;
    cycle();

    // Backpressure instance
    sel = 1'b1;
    model_clear();
    check_status("t5_init");
    for (int i = 0; i < DEPTH; i++) push_word(8'h60 + 8'(i));
    check_status("t5_full");
    check("t5_in_ready_low", o_ready, 1'b0);
    pop_check("t5_pop1");
    check("t5_in_ready_back", o_ready, 1'b1);
    for (int i = 0; i < 10; i++) pop_check("t5_pop");
    check("t5_level5", o_level, 5'd5);
    flush = 1'b1; in_data = 8'hCC; in_valid = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    check_status("t5_flush");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
